// File: rtl/index_pair_fetch_if.sv
// Bundle between index_pair_fetch and its neighbours: index pair in,
// memory read port, and the fetched pair out.
// Ports: idx_valid/idx_ready/index_1/index_2 (pair in),
//   mem_req/mem_addr/mem_rdata (memory), pair_valid/pair_ready/
//   data_1/data_2/out_index_1/out_index_2/pair_count (pair out).
interface index_pair_fetch_if #(
  parameter int ADDR_BITWIDTH = 8,
  parameter int DATA_BITWIDTH = 16,
  parameter int CNT_BITWIDTH  = 16
);
  logic                     idx_valid;
  logic                     idx_ready;
  logic [ADDR_BITWIDTH-1:0] index_1;
  logic [ADDR_BITWIDTH-1:0] index_2;
  logic                     mem_req;
  logic [ADDR_BITWIDTH-1:0] mem_addr;
  logic [DATA_BITWIDTH-1:0] mem_rdata;
  logic                     pair_valid;
  logic                     pair_ready;
  logic [DATA_BITWIDTH-1:0] data_1;
  logic [DATA_BITWIDTH-1:0] data_2;
  logic [ADDR_BITWIDTH-1:0] out_index_1;
  logic [ADDR_BITWIDTH-1:0] out_index_2;
  logic [CNT_BITWIDTH-1:0]  pair_count;

  // Fetch block side
  modport slave (
    input  idx_valid, index_1, index_2,
    input  mem_rdata, pair_ready,
    output idx_ready, mem_req, mem_addr,
    output pair_valid, data_1, data_2,
    output out_index_1, out_index_2,
    output pair_count
  );

  // Environment side: generator, memory, consumer
  modport master (
    output idx_valid, index_1, index_2,
    output mem_rdata, pair_ready,
    input  idx_ready, mem_req, mem_addr,
    input  pair_valid, data_1, data_2,
    input  out_index_1, out_index_2,
    input  pair_count
  );
endinterface

// File: rtl/index_pair_fetch.sv
// Accepts an (index_1, index_2) pair, reads both words through one
// single-port synchronous memory (one read if the indices are equal),
// then holds data and indices on a valid/ready output.
// Ports: clk, reset (async, active high), bus (index_pair_fetch_if.slave).
module index_pair_fetch #(
  parameter int ADDR_BITWIDTH = 8,
  parameter int DATA_BITWIDTH = 16,
  parameter int CNT_BITWIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  index_pair_fetch_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WAIT,
    OUT
  } state_t;

  state_t                   state_q;
  logic                     dup_q;
  logic                     idx_ready_q;
  logic                     mem_req_q;
  logic [ADDR_BITWIDTH-1:0] mem_addr_q;
  logic                     pair_valid_q;
  logic [DATA_BITWIDTH-1:0] data_1_q;
  logic [DATA_BITWIDTH-1:0] data_2_q;
  logic [ADDR_BITWIDTH-1:0] oidx_1_q;
  logic [ADDR_BITWIDTH-1:0] oidx_2_q;
  logic [CNT_BITWIDTH-1:0]  cnt_q;

  // Outputs are registered one state ahead: the strobe and address
  // for RD1 are loaded on the accepting edge, so mem_req is high
  // exactly while the FSM sits in RD1/RD2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dup_q        <= 1'b0;
      idx_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pair_valid_q <= 1'b0;
      data_1_q     <= '0;
      data_2_q     <= '0;
      oidx_1_q     <= '0;
      oidx_2_q     <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.idx_valid) begin
            oidx_1_q    <= bus.index_1;
            oidx_2_q    <= bus.index_2;
            idx_ready_q <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= bus.index_1;
            state_q     <= RD1;
          end
        end
        RD1: begin
          if (oidx_1_q != oidx_2_q) begin
            mem_addr_q <= oidx_2_q;
            state_q    <= RD2;
          end else begin
            // Same word twice: one read serves both slots
            dup_q      <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            state_q    <= WAIT;
          end
        end
        RD2: begin
          data_1_q   <= bus.mem_rdata;
          mem_req_q  <= 1'b0;
          mem_addr_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          data_2_q <= bus.mem_rdata;
          if (dup_q) begin
            data_1_q <= bus.mem_rdata;
          end
          pair_valid_q <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          if (bus.pair_ready) begin
            pair_valid_q <= 1'b0;
            cnt_q        <= cnt_q + CNT_BITWIDTH'(1);
            dup_q        <= 1'b0;
            idx_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          dup_q        <= 1'b0;
          idx_ready_q  <= 1'b1;
          mem_req_q    <= 1'b0;
          mem_addr_q   <= '0;
          pair_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.idx_ready   = idx_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.pair_valid  = pair_valid_q;
  assign bus.data_1      = data_1_q;
  assign bus.data_2      = data_2_q;
  assign bus.out_index_1 = oidx_1_q;
  assign bus.out_index_2 = oidx_2_q;
  assign bus.pair_count  = cnt_q;

endmodule

// File: tb/tb_index_pair_fetch.sv
// Bench for index_pair_fetch: directed vector table, reset mid-fetch,
// counter wrap (4-bit counter build) and a back-to-back stream.
module tb_index_pair_fetch;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  index_pair_fetch_if #(
    .ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .CNT_BITWIDTH(CW)
  ) bus ();

  index_pair_fetch #(
    .ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .CNT_BITWIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem [256];

  // Synchronous read memory; junk when not strobed
  always @(posedge clk)
    bus.mem_rdata <= bus.mem_req ? mem[bus.mem_addr] : 16'hDEAD;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] cnt_m;

  typedef struct {
    logic [AW-1:0] i1;
    logic [AW-1:0] i2;
    int            lat;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    int            hold;
  } vec_t;

  typedef struct {
    logic [AW-1:0] i1;
    logic [AW-1:0] i2;
  } pair_t;

  vec_t  vt[6];
  pair_t q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs;
    chk("rst_idx_ready", bus.idx_ready, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_pair_valid", bus.pair_valid, 0);
    chk("rst_data_1", bus.data_1, 0);
    chk("rst_data_2", bus.data_2, 0);
    chk("rst_oidx_1", bus.out_index_1, 0);
    chk("rst_oidx_2", bus.out_index_2, 0);
    chk("rst_count", bus.pair_count, 0);
  endtask

  // Called at a sample point with the DUT idle; leaves it idle.
  task automatic run_pair(input logic [AW-1:0] i1, input logic [AW-1:0] i2,
                          input int lat, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input int hold);
    int nreq;
    int seen;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    nreq = 0;
    seen = 0;
    a0 = '0;
    a1 = '0;
    chk("idle_ready", bus.idx_ready, 1);
    bus.idx_valid = 1'b1;
    bus.index_1 = i1;
    bus.index_2 = i2;
    tick;
    // Keep offering junk: must be ignored while busy
    bus.index_1 = ~i1;
    bus.index_2 = i1;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      if (bus.pair_valid) begin
        seen = c;
      end else begin
        chk("busy_ready", bus.idx_ready, 0);
        if (bus.mem_req) begin
          if (nreq == 0) a0 = bus.mem_addr;
          else a1 = bus.mem_addr;
          nreq++;
        end else begin
          chk("addr_zero", bus.mem_addr, 0);
        end
        tick;
      end
    end
    chk("latency", seen, lat);
    chk("nreq", nreq, (lat == 4) ? 2 : 1);
    chk("addr1", a0, i1);
    if (lat == 4) chk("addr2", a1, i2);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", bus.pair_valid, 1);
      chk("hold_d1", bus.data_1, d1);
      chk("hold_d2", bus.data_2, d2);
      chk("hold_ready", bus.idx_ready, 0);
      chk("hold_req", bus.mem_req, 0);
      tick;
    end
    chk("data_1", bus.data_1, d1);
    chk("data_2", bus.data_2, d2);
    chk("oidx_1", bus.out_index_1, i1);
    chk("oidx_2", bus.out_index_2, i2);
    chk("count_pre", bus.pair_count, cnt_m);
    bus.idx_valid = 1'b0;
    bus.pair_ready = 1'b1;
    tick;
    bus.pair_ready = 1'b0;
    cnt_m++;
    chk("post_valid", bus.pair_valid, 0);
    chk("post_count", bus.pair_count, cnt_m);
    chk("post_ready", bus.idx_ready, 1);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    chk_reset_outs();
    @(negedge clk);
    reset = 1'b0;
    tick;
    cnt_m = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    int acc;
    int done;
    int last;
    logic took;
    pair_t p;

    for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
    mem[3] = 16'hA5A5;
    mem[9] = 16'h0F0F;
    mem[5] = 16'h1234;

    vt[0] = '{8'h03, 8'h09, 4, 16'hA5A5, 16'h0F0F, 0};
    vt[1] = '{8'h05, 8'h05, 3, 16'h1234, 16'h1234, 0};
    vt[2] = '{8'h10, 8'h20, 4, 16'h10EF, 16'h20DF, 10};
    vt[3] = '{8'hFF, 8'h00, 4, 16'hFF00, 16'h00FF, 0};
    vt[4] = '{8'h07, 8'h07, 3, 16'h07F8, 16'h07F8, 3};
    vt[5] = '{8'h80, 8'h7F, 4, 16'h807F, 16'h7F80, 0};

    reset = 1'b1;
    bus.idx_valid = 1'b0;
    bus.pair_ready = 1'b0;
    bus.index_1 = '0;
    bus.index_2 = '0;
    cnt_m = '0;
    #12;
    chk_reset_outs();
    @(negedge clk);
    reset = 1'b0;
    tick;

    for (int v = 0; v < 6; v++)
      run_pair(vt[v].i1, vt[v].i2, vt[v].lat,
               vt[v].d1, vt[v].d2, vt[v].hold);

    // Reset while the second read is on the bus
    bus.idx_valid = 1'b1;
    bus.index_1 = 8'h21;
    bus.index_2 = 8'h42;
    tick;
    bus.idx_valid = 1'b0;
    tick;
    chk("rd2_req", bus.mem_req, 1);
    chk("rd2_addr", bus.mem_addr, 8'h42);
    do_reset();
    run_pair(8'h33, 8'h44, 4, 16'h33CC, 16'h44BB, 0);
    chk("restart_count", bus.pair_count, 1);

    // Counter wrap on the 4-bit build
    do_reset();
    for (int k = 0; k < 15; k++)
      run_pair(8'(k + 8'h40), 8'(k + 8'h40), 3,
               {8'(k + 8'h40), ~8'(k + 8'h40)},
               {8'(k + 8'h40), ~8'(k + 8'h40)}, 0);
    chk("count_full", bus.pair_count, 4'hF);
    run_pair(8'h60, 8'h61, 4, 16'h609F, 16'h619E, 0);
    chk("count_wrap", bus.pair_count, 0);

    // Back-to-back stream with the consumer always ready
    acc = 0;
    done = 0;
    last = -1;
    bus.pair_ready = 1'b1;
    bus.idx_valid = 1'b1;
    bus.index_1 = 8'($urandom_range(0, 255));
    bus.index_2 = bus.index_1 ^ 8'($urandom_range(1, 255));
    for (int cyc = 0; cyc < 600 && done < 50; cyc++) begin
      took = 1'b0;
      if (bus.pair_valid) begin
        if (q.size() == 0) begin
          chk("b2b_spurious", 1, 0);
        end else begin
          p = q.pop_front();
          chk("b2b_d1", bus.data_1, mem[p.i1]);
          chk("b2b_d2", bus.data_2, mem[p.i2]);
          chk("b2b_oidx_1", bus.out_index_1, p.i1);
          chk("b2b_oidx_2", bus.out_index_2, p.i2);
          chk("b2b_count", bus.pair_count, cnt_m);
        end
        cnt_m++;
        done++;
      end
      if (bus.idx_ready && bus.idx_valid) begin
        if (last >= 0) chk("b2b_interval", cyc - last, 5);
        last = cyc;
        q.push_back('{bus.index_1, bus.index_2});
        acc++;
        took = 1'b1;
      end
      tick;
      if (took) begin
        if (acc < 50) begin
          bus.index_1 = 8'($urandom_range(0, 255));
          bus.index_2 = bus.index_1 ^ 8'($urandom_range(1, 255));
        end else begin
          bus.idx_valid = 1'b0;
        end
      end
    end
    chk("b2b_done", done, 50);
    chk("b2b_count_end", bus.pair_count, cnt_m);
    bus.pair_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
